// File: rtl/score_counter.sv
// Score accumulator for the Space Invaders HUD: saturating score, persistent high score,
// extra-life pulses at fixed score intervals and a frame-timed new-high-score flash.
module score_counter #(
    parameter int MAX_SCORE    = 999,
    parameter int LIFE_STEP    = 250,
    parameter int PTS_TYPE0    = 10,
    parameter int PTS_TYPE1    = 20,
    parameter int PTS_TYPE2    = 30,
    parameter int PTS_TYPE3    = 50,
    parameter int FLASH_FRAMES = 32
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       new_game,
    input  logic       game_over,
    input  logic       start_of_frame,
    input  logic       hit_valid,
    input  logic [1:0] hit_type,
    input  logic       bonus_valid,
    input  logic [6:0] bonus_points,
    output logic [9:0] score,
    output logic [9:0] high_score,
    output logic       score_changed,
    output logic       extra_life,
    output logic       hs_flash,
    output logic       playing
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] PLAY = 2'd1;
    localparam logic [1:0] OVER = 2'd2;

    localparam int             FW         = $clog2(FLASH_FRAMES + 1);
    localparam logic [10:0]    MAX11      = 11'(MAX_SCORE);
    localparam logic [10:0]    STEP11     = 11'(LIFE_STEP);
    localparam logic [FW-1:0]  FLASH_LOAD = FW'(FLASH_FRAMES);

    logic [1:0]    state;
    logic [10:0]   next_life;
    logic [FW-1:0] flash_cnt;
    logic          hs_beaten;

    logic          upd;
    logic [10:0]   sum;
    logic [9:0]    new_score;
    logic          life_hit;
    logic          hs_new;

    function automatic logic [10:0] hit_pts(input logic [1:0] t);
        case (t)
            2'd0:    return 11'(PTS_TYPE0);
            2'd1:    return 11'(PTS_TYPE1);
            2'd2:    return 11'(PTS_TYPE2);
            default: return 11'(PTS_TYPE3);
        endcase
    endfunction

    function automatic logic [9:0] sat_score(input logic [10:0] s);
        return (s > MAX11) ? MAX11[9:0] : s[9:0];
    endfunction

    // new_game overrides any event arriving in the same cycle
    always_comb begin
        upd       = (state == PLAY) && !new_game && (hit_valid || bonus_valid);
        sum       = {1'b0, score}
                  + (hit_valid   ? hit_pts(hit_type)     : 11'd0)
                  + (bonus_valid ? {4'd0, bonus_points}  : 11'd0);
        new_score = sat_score(sum);
        life_hit  = (next_life <= MAX11) && ({1'b0, new_score} >= next_life);
        hs_new    = new_score > high_score;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state         <= IDLE;
            score         <= 10'd0;
            high_score    <= 10'd0;
            next_life     <= STEP11;
            flash_cnt     <= '0;
            hs_beaten     <= 1'b0;
            score_changed <= 1'b0;
            extra_life    <= 1'b0;
        end else if (new_game) begin
            state         <= PLAY;
            score_changed <= (score != 10'd0);
            extra_life    <= 1'b0;
            score         <= 10'd0;
            next_life     <= STEP11;
            hs_beaten     <= 1'b0;
            flash_cnt     <= '0;
        end else begin
            score_changed <= upd && (new_score != score);
            extra_life    <= upd && life_hit;
            if (upd)
                score <= new_score;
            if (upd && life_hit)
                next_life <= next_life + STEP11;
            if (upd && hs_new)
                high_score <= new_score;
            // flash window starts only on the first improvement of a game
            if (upd && hs_new && !hs_beaten) begin
                hs_beaten <= 1'b1;
                flash_cnt <= FLASH_LOAD;
            end else if (start_of_frame && (flash_cnt != '0)) begin
                flash_cnt <= flash_cnt - FW'(1);
            end
            if ((state == PLAY) && game_over)
                state <= OVER;
        end
    end

    assign hs_flash = (flash_cnt != '0);
    assign playing  = (state == PLAY);

endmodule

// File: doc/score_counter.md
Name: score_counter

Overview:
- Game-side score accumulator for the Space Invaders display path.
- Converts hit and bonus events into a saturating 10-bit binary score and a persistent high score.
- Feeds the binary-to-decimal digit converter, which drives the on-screen score digits.
- Also issues extra-life pulses at score thresholds and a high-score flash flag for the HUD.

Parameters:
- MAX_SCORE, 999, saturation ceiling; must fit the 3 digits of the downstream converter.
- LIFE_STEP, 250, score interval between extra-life awards.
- PTS_TYPE0, 10, points for hit_type 0 (bottom-row alien).
- PTS_TYPE1, 20, points for hit_type 1 (middle-row alien).
- PTS_TYPE2, 30, points for hit_type 2 (top-row alien).
- PTS_TYPE3, 50, points for hit_type 3 (UFO).
- FLASH_FRAMES, 32, frames that hs_flash stays high after a new high score.

Ports:
- clk  in  1  system clock
- resetN  in  1  reset, asynchronous, active-low
- new_game  in  1  single-cycle pulse; starts a game
- game_over  in  1  single-cycle pulse; ends a game
- start_of_frame  in  1  single-cycle pulse, once per VGA frame
- hit_valid  in  1  single-cycle pulse; an alien was destroyed
- hit_type  in  2  alien class, sampled when hit_valid=1
- bonus_valid  in  1  single-cycle pulse; bonus award
- bonus_points  in  7  bonus value 0..127, sampled when bonus_valid=1
- score  out  10  current score, 0..MAX_SCORE
- high_score  out  10  best score since reset
- score_changed  out  1  one-cycle pulse when score changes value
- extra_life  out  1  one-cycle pulse when a life threshold is crossed
- hs_flash  out  1  high during the new-high-score flash window
- playing  out  1  high in state PLAY

Behaviour:
- Reset (asynchronous, resetN=0) sets:
  - state = IDLE
  - score = 0, high_score = 0
  - next_life = LIFE_STEP
  - flash counter = 0, hs_beaten = 0
  - all pulse outputs = 0, hs_flash = 0, playing = 0
- Reset asserted mid-game aborts immediately; no partial update survives.
- State machine:
  - IDLE -> PLAY on new_game.
  - PLAY -> OVER on game_over.
  - OVER -> PLAY on new_game.
  - PLAY -> PLAY on new_game (restart).
  - playing = 1 only in PLAY.
- Every new_game does all of the following, registered, with one-cycle latency:
  - score = 0, next_life = LIFE_STEP, hs_beaten = 0, flash counter = 0.
  - high_score is kept.
  - score_changed pulses only if the previous score was nonzero.
- Accepting events:
  - Events are accepted only in PLAY; in IDLE and OVER they are ignored.
  - hit and bonus in the same cycle are both applied.
  - sum = score + pts(hit_type)·hit_valid + bonus_points·bonus_valid, computed in 11 bits.
  - new_score = min(sum, MAX_SCORE).
  - score registers new_score on the clock edge following the event cycle (latency 1).
- Simultaneous control and events:
  - new_game in the same cycle as hit/bonus: new_game wins, the events are dropped.
  - game_over in the same cycle as hit/bonus: the events are applied, then the state goes to OVER.
  - new_game and game_over in the same cycle: new_game wins.
- score_changed is high in the cycle score takes a value different from its previous value. At saturation, further hits produce no pulse.
- extra_life:
  - Pulses in the same cycle as the score update when next_life ≤ MAX_SCORE and new_score ≥ next_life.
  - next_life then advances by exactly LIFE_STEP, held in an 11-bit register.
  - At most one pulse per update; a remaining crossing fires on the next score update.
  - Once next_life > MAX_SCORE, no further lives are awarded.
- high_score:
  - Updates in the same cycle as score whenever new_score > high_score.
  - On the first such update in a game: set hs_beaten, load the flash counter with FLASH_FRAMES.
- hs_flash:
  - hs_flash = (flash counter ≠ 0).
  - The counter decrements on each start_of_frame while nonzero, and stops at 0.
  - It is not reloaded by later improvements in the same game.
- Outputs hold their values in OVER, so the final score stays displayed.

Test Plan:
- Reset, then new_game, then hit_type=0,1,2,3 in consecutive cycles -> score 10, 30, 60, 110, each updating 1 cycle after its hit; score_changed high 4 cycles; high_score tracks score; hs_flash rises with the first update.
- Same cycle hit_type=3 + bonus_valid with bonus_points=100 from score 240 -> score 390, one extra_life pulse, next_life=500.
- Score 980, hit_type=2 -> score 999 (saturated), score_changed pulse; another hit -> score stays 999, no score_changed, extra_life pulse (pending threshold 750) only if not yet awarded.
- hit_valid in IDLE, and in OVER after game_over -> score unchanged, no pulses; new_game with hit in the same cycle -> score 0, hit dropped.
- Game 1 ends at 300; game 2 reaches 200 -> high_score stays 300, hs_flash low; reaching 310 -> high_score 310, hs_flash high for exactly 32 start_of_frame pulses, then low.
- resetN low mid-game at score 500 -> score 0, high_score 0, state IDLE, all outputs 0 asynchronously.
